div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- EX-stage sequencer sitting directly upstream of the multi-cycle divider.
- Accepts DIV/DIVU requests from EX, drives the divider start/annul/operand handshake, and stalls the pipeline while the divider runs.
- Captures the 64-bit quotient/remainder and issues a one-cycle HI/LO write. Handles flush-abort and divider drain.

Parameters:
- DRAIN_CYCLES, 2: cycles div_start_o is held low after an abort before a new request is accepted; minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset; clears state on the rising edge when rst==0.
- div_req_i  in  1  EX holds a DIV/DIVU instruction; held stable while stallreq_o=1.
- signed_i  in  1  1 = DIV, 0 = DIVU.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- flush_i  in  1  pipeline flush (exception/eret); kills the in-flight divide.
- div_result_i  in  64  from divider: {remainder, quotient}.
- div_ready_i  in  1  from divider: result valid.
- div_start_o  out  1  to divider start.
- div_annul_o  out  1  to divider annul.
- div_signed_o  out  1  registered copy of signed_i.
- div_opdata1_o  out  32  registered dividend.
- div_opdata2_o  out  32  registered divisor.
- stallreq_o  out  1  pipeline stall request.
- whilo_o  out  1  HI/LO write enable, one-cycle pulse.
- hi_o  out  32  remainder.
- lo_o  out  32  quotient.

Behaviour:
- States: IDLE, RUN, DONE, DRAIN.
- Reset values: state=IDLE; all registered outputs 0 (div_start_o, div_signed_o, operands, whilo_o, hi_o, lo_o). Divider shares rst, so reset mid-operation returns both blocks to idle with no HI/LO write.
- IDLE:
  - Request accepted when div_req_i=1 and flush_i=0.
  - On acceptance: latch signed_i/opdata1_i/opdata2_i into div_* outputs; next state RUN.
- RUN:
  - div_start_o=1 (registered, high for every RUN cycle).
  - Operands stay frozen until the state leaves RUN. The divider re-reads them for sign fix-up at the end.
  - div_ready_i=1 and flush_i=0: hi_o<=div_result_i[63:32], lo_o<=div_result_i[31:0]; next state DONE.
- DONE:
  - whilo_o=1 for exactly this cycle; div_start_o=0; stallreq_o=0, so the pipeline advances on this edge.
  - Next state IDLE unconditionally. The instruction still present in EX this cycle must not be re-accepted.
- Flush:
  - In RUN, flush_i=1 makes div_annul_o=1 combinationally; next state DRAIN with no capture and no write.
  - Flush wins over a simultaneous div_ready_i.
  - Flush in IDLE blocks acceptance.
  - Flush in DONE has no effect; the write still occurs.
- DRAIN:
  - div_start_o=0 for DRAIN_CYCLES cycles (counter), then IDLE. Requests ignored during DRAIN.
  - Guarantees the divider has left its divide-by-zero/end states before the next start.
- stallreq_o is combinational: 1 when (IDLE and div_req_i and !flush_i) or RUN or DRAIN-with-div_req_i; otherwise 0.
- whilo_o, hi_o and lo_o are registered; hi_o/lo_o hold their value after DONE.
- Latency, acceptance edge = cycle 0:
  - Nonzero divisor: whilo_o in cycle 37; stallreq_o high in cycles 0..36.
  - Zero divisor: whilo_o in cycle 5, with hi_o=lo_o=0.
  - General rule: DONE is always exactly one cycle after div_ready_i is sampled high.
- Divide-by-zero needs no special handling here; the divider returns 0 and the normal write path applies.

Optional Feature:
- Macro DIV_FASTPATH_EN.
- Defined: in IDLE, an accepted request with opdata2_i==1, or opdata1_i==0 with opdata2_i!=0, bypasses the divider.
  - Fast result: lo_o<=opdata1_i (0 in the zero-dividend case), hi_o<=0; next state DONE.
  - div_start_o never rises. stallreq_o is high in cycle 0 only; whilo_o in cycle 1.
- Undefined: every request takes the full divider path; results are identical, only latency differs.

Test Plan:
- DIVU 100/7 -> whilo_o pulse at cycle 37, lo_o=14, hi_o=2; stallreq_o high cycles 0..36 then low.
- DIV 0xFFFFFFF9/2 (-7/2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; div_opdata1_o stable throughout RUN.
- DIVU 5/0 -> whilo_o at cycle 5, hi_o=lo_o=0.
- DIVU 1000/3 with flush_i pulsed at cycle 10 -> div_annul_o=1 that cycle, no whilo_o, 2 DRAIN cycles. Then DIVU 9/3 -> lo_o=3, hi_o=0.
- rst=0 at cycle 20 of a divide -> all outputs 0, state IDLE; next DIVU 8/2 completes with lo_o=4, hi_o=0.
- DIV_FASTPATH_EN defined, DIVU 0x12345678/1 -> whilo_o at cycle 1, lo_o=0x12345678, hi_o=0, div_start_o never 1. Undefined: same values at cycle 37.

Source files
------------

// File: rtl/div_issue_ctrl_if.sv
// EX <-> divider handshake bundle for div_issue_ctrl.
// slave: the sequencer's side; master: the EX stage and divider side.
interface div_issue_ctrl_if;
    localparam int unsigned DATA_W = 32;

    logic                  div_req_i;
    logic                  signed_i;
    logic [DATA_W-1:0]     opdata1_i;
    logic [DATA_W-1:0]     opdata2_i;
    logic                  flush_i;
    logic [2*DATA_W-1:0]   div_result_i;
    logic                  div_ready_i;

    logic                  div_start_o;
    logic                  div_annul_o;
    logic                  div_signed_o;
    logic [DATA_W-1:0]     div_opdata1_o;
    logic [DATA_W-1:0]     div_opdata2_o;
    logic                  stallreq_o;
    logic                  whilo_o;
    logic [DATA_W-1:0]     hi_o;
    logic [DATA_W-1:0]     lo_o;

    modport slave (
        input  div_req_i, signed_i, opdata1_i, opdata2_i, flush_i,
               div_result_i, div_ready_i,
        output div_start_o, div_annul_o, div_signed_o, div_opdata1_o,
               div_opdata2_o, stallreq_o, whilo_o, hi_o, lo_o
    );

    modport master (
        output div_req_i, signed_i, opdata1_i, opdata2_i, flush_i,
               div_result_i, div_ready_i,
        input  div_start_o, div_annul_o, div_signed_o, div_opdata1_o,
               div_opdata2_o, stallreq_o, whilo_o, hi_o, lo_o
    );
endinterface

// File: rtl/div_issue_ctrl.sv
// EX-stage sequencer in front of the multi-cycle divider: issue, stall, HI/LO write, flush drain.
// Optional macro DIV_FASTPATH_EN: divide-by-one and zero-dividend requests skip the divider.
module div_issue_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    div_issue_ctrl_if.slave   bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DRAIN_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    drain_q, drain_d;
    logic                start_q, start_d;
    logic                signed_q, signed_d;
    logic [DATA_W-1:0]   op1_q, op1_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic                whilo_q, whilo_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                stall_c;
    logic                annul_c;
    logic                accept_c;

    assign accept_c = bus.div_req_i && !bus.flush_i;

`ifdef DIV_FASTPATH_EN
    logic fast_hit_c;
    assign fast_hit_c = (bus.opdata2_i == DATA_W'(1)) ||
                        ((bus.opdata1_i == '0) && (bus.opdata2_i != '0));
`endif

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            start_q  <= 1'b0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            whilo_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            start_q  <= start_d;
            signed_q <= signed_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            whilo_q  <= whilo_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Next state; start/whilo are computed for the state being entered
    always_comb begin
        state_d  = state_q;
        drain_d  = drain_q;
        start_d  = 1'b0;
        signed_d = signed_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        whilo_d  = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        stall_c  = 1'b0;
        annul_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    stall_c  = 1'b1;
                    signed_d = bus.signed_i;
                    op1_d    = bus.opdata1_i;
                    op2_d    = bus.opdata2_i;
`ifdef DIV_FASTPATH_EN
                    if (fast_hit_c) begin
                        lo_d    = bus.opdata1_i;
                        hi_d    = '0;
                        whilo_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        start_d = 1'b1;
                        state_d = RUN;
                    end
`else
                    start_d = 1'b1;
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                stall_c = 1'b1;
                // Flush beats a same-cycle ready: no capture, no write
                if (bus.flush_i) begin
                    annul_c = 1'b1;
                    drain_d = CNT_W'(DRAIN_CYCLES - 1);
                    state_d = DRAIN;
                end else if (bus.div_ready_i) begin
                    hi_d    = bus.div_result_i[2*DATA_W-1:DATA_W];
                    lo_d    = bus.div_result_i[DATA_W-1:0];
                    whilo_d = 1'b1;
                    state_d = DONE;
                end else begin
                    start_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                stall_c = bus.div_req_i;
                if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = CNT_W'(drain_q - 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.div_start_o   = start_q;
    assign bus.div_annul_o   = annul_c;
    assign bus.div_signed_o  = signed_q;
    assign bus.div_opdata1_o = op1_q;
    assign bus.div_opdata2_o = op2_q;
    assign bus.stallreq_o    = stall_c;
    assign bus.whilo_o       = whilo_q;
    assign bus.hi_o          = hi_q;
    assign bus.lo_o          = lo_q;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl with a behavioural divider (36 start cycles, 4 on divide-by-zero).
module tb_div_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [5:0] dcnt;

    div_issue_ctrl_if bus ();

    div_issue_ctrl #(.DRAIN_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Divider model: ready after 36 start-high cycles, 4 when dividing by zero
    always_ff @(posedge clk) begin
        if (!rst) dcnt <= '0;
        else if (bus.div_start_o && !bus.div_annul_o && !bus.div_ready_i) dcnt <= dcnt + 6'd1;
        else dcnt <= '0;
    end

    assign bus.div_ready_i = bus.div_start_o &&
                             (dcnt == ((bus.div_opdata2_o == '0) ? 6'd3 : 6'd35));

    always_comb begin
        bus.div_result_i = '0;
        if (bus.div_opdata2_o != '0) begin
            if (bus.div_signed_o)
                bus.div_result_i = {32'($signed(bus.div_opdata1_o) % $signed(bus.div_opdata2_o)),
                                    32'($signed(bus.div_opdata1_o) / $signed(bus.div_opdata2_o))};
            else
                bus.div_result_i = {bus.div_opdata1_o % bus.div_opdata2_o,
                                    bus.div_opdata1_o / bus.div_opdata2_o};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    // Present one request at the current cycle and observe until whilo or budget runs out
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input int flush_at, input int budget,
                           output int lat, output int first_nostall, output int start_cnt,
                           output int annul_at, output bit op_bad);
        lat = -1; first_nostall = -1; start_cnt = 0; annul_at = -1; op_bad = 1'b0;
        bus.div_req_i = 1'b1; bus.signed_i = sgn; bus.opdata1_i = a; bus.opdata2_i = b;
        for (int c = 0; c < budget; c++) begin
            bus.flush_i = (c == flush_at);
            @(negedge clk);
            if (!bus.stallreq_o && first_nostall < 0) first_nostall = c;
            if (bus.div_annul_o) annul_at = c;
            if (bus.whilo_o && lat < 0) lat = c;
            if (bus.div_start_o) begin
                start_cnt++;
                if (bus.div_opdata1_o !== a || bus.div_opdata2_o !== b || bus.div_signed_o !== sgn)
                    op_bad = 1'b1;
            end
            @(posedge clk); #1;
            bus.flush_i = 1'b0;
            if (c == flush_at) bus.div_req_i = 1'b0;
            if (lat >= 0) break;
        end
        bus.div_req_i = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({bus.div_start_o, bus.div_signed_o, bus.div_opdata1_o, bus.div_opdata2_o} !== '0) begin
            n_err++; $display("FAIL reset_issue: got %0b/%0b/%h/%h want all 0", bus.div_start_o,
                              bus.div_signed_o, bus.div_opdata1_o, bus.div_opdata2_o);
        end
        n_cmp++;
        if ({bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o, bus.div_annul_o} !== '0) begin
            n_err++; $display("FAIL reset_result: got whilo=%0b hi=%h lo=%h stall=%0b annul=%0b want all 0",
                              bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o, bus.div_annul_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_divu_basic();
        int lat, nst, sc, an; bit ob;
        run_div(1'b0, 32'd100, 32'd7, -1, 60, lat, nst, sc, an, ob);
        n_cmp++; if (lat !== 37) begin n_err++; $display("FAIL divu_lat: got %0d want 37", lat); end
        n_cmp++; if (nst !== 37) begin n_err++; $display("FAIL divu_stall_end: got %0d want 37", nst); end
        n_cmp++; if (sc !== 36) begin n_err++; $display("FAIL divu_start_cycles: got %0d want 36", sc); end
        n_cmp++; if (lo_hi_ok(32'd14, 32'd2) == 1'b0) begin n_err++;
            $display("FAIL divu_result: got lo=%0d hi=%0d want lo=14 hi=2", bus.lo_o, bus.hi_o); end
        @(negedge clk);
        n_cmp++; if (bus.whilo_o !== 1'b0 || bus.lo_o !== 32'd14) begin n_err++;
            $display("FAIL divu_hold: got whilo=%0b lo=%0d want whilo=0 lo=14", bus.whilo_o, bus.lo_o); end
        @(posedge clk); #1;
    endtask

    function automatic bit lo_hi_ok(input logic [31:0] lo, input logic [31:0] hi);
        return (bus.lo_o === lo) && (bus.hi_o === hi);
    endfunction

    task automatic test_div_signed();
        int lat, nst, sc, an; bit ob;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 60, lat, nst, sc, an, ob);
        n_cmp++; if (lat !== 37) begin n_err++; $display("FAIL div_lat: got %0d want 37", lat); end
        n_cmp++; if (ob !== 1'b0) begin n_err++; $display("FAIL div_operands_stable: got %0b want 0", ob); end
        n_cmp++; if (bus.lo_o !== 32'hFFFF_FFFD || bus.hi_o !== 32'hFFFF_FFFF) begin n_err++;
            $display("FAIL div_result: got lo=%h hi=%h want lo=fffffffd hi=ffffffff", bus.lo_o, bus.hi_o); end
    endtask

    task automatic test_div_by_zero();
        int lat, nst, sc, an; bit ob;
        run_div(1'b0, 32'd5, 32'd0, -1, 60, lat, nst, sc, an, ob);
        n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL dbz_lat: got %0d want 5", lat); end
        n_cmp++; if (nst !== 5) begin n_err++; $display("FAIL dbz_stall_end: got %0d want 5", nst); end
        n_cmp++; if (bus.lo_o !== 32'd0 || bus.hi_o !== 32'd0) begin n_err++;
            $display("FAIL dbz_result: got lo=%h hi=%h want 0/0", bus.lo_o, bus.hi_o); end
    endtask

    task automatic test_flush_run();
        int lat, nst, sc, an; bit ob;
        run_div(1'b0, 32'd1000, 32'd3, 10, 11, lat, nst, sc, an, ob);
        n_cmp++; if (an !== 10) begin n_err++; $display("FAIL flush_annul: got cycle %0d want 10", an); end
        n_cmp++; if (lat !== -1) begin n_err++; $display("FAIL flush_nowrite: got whilo at %0d want none", lat); end
        // Next request waits out both drain cycles
        bus.div_req_i = 1'b1; bus.signed_i = 1'b0; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd3;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.stallreq_o, bus.div_start_o, bus.whilo_o} !== 3'b100) begin n_err++;
                $display("FAIL drain_cycle%0d: got stall/start/whilo=%b want 100", c,
                         {bus.stallreq_o, bus.div_start_o, bus.whilo_o}); end
            @(posedge clk); #1;
        end
        run_div(1'b0, 32'd9, 32'd3, -1, 60, lat, nst, sc, an, ob);
        n_cmp++; if (lat !== 37) begin n_err++; $display("FAIL after_drain_lat: got %0d want 37", lat); end
        n_cmp++; if (bus.lo_o !== 32'd3 || bus.hi_o !== 32'd0) begin n_err++;
            $display("FAIL after_drain_result: got lo=%0d hi=%0d want lo=3 hi=0", bus.lo_o, bus.hi_o); end
    endtask

    task automatic test_flush_idle();
        bus.div_req_i = 1'b1; bus.flush_i = 1'b1; bus.signed_i = 1'b0;
        bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
        @(negedge clk);
        n_cmp++; if (bus.stallreq_o !== 1'b0) begin n_err++;
            $display("FAIL flush_idle_stall: got %0b want 0", bus.stallreq_o); end
        @(posedge clk); #1;
        bus.div_req_i = 1'b0; bus.flush_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.div_start_o !== 1'b0) begin n_err++;
            $display("FAIL flush_idle_accept: got start=%0b want 0", bus.div_start_o); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush_collisions();
        int lat, nst, sc, an; bit ob;
        run_div(1'b0, 32'd100, 32'd7, 37, 60, lat, nst, sc, an, ob);
        n_cmp++; if (lat !== 37 || an !== -1) begin n_err++;
            $display("FAIL flush_in_done: got whilo at %0d annul at %0d want 37/-1", lat, an); end
        n_cmp++; if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin n_err++;
            $display("FAIL flush_in_done_result: got lo=%0d hi=%0d want 14/2", bus.lo_o, bus.hi_o); end
        run_div(1'b0, 32'd50, 32'd4, 36, 40, lat, nst, sc, an, ob);
        n_cmp++; if (an !== 36 || lat !== -1) begin n_err++;
            $display("FAIL flush_vs_ready: got annul at %0d whilo at %0d want 36/-1", an, lat); end
        n_cmp++; if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin n_err++;
            $display("FAIL flush_vs_ready_hold: got lo=%0d hi=%0d want 14/2", bus.lo_o, bus.hi_o); end
    endtask

    task automatic test_reset_midop();
        int lat, nst, sc, an; bit ob;
        run_div(1'b1, 32'd1000, 32'd3, -1, 20, lat, nst, sc, an, ob);
        n_cmp++; if (sc !== 19) begin n_err++; $display("FAIL midop_progress: got %0d want 19", sc); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.div_start_o, bus.div_signed_o, bus.div_opdata1_o, bus.div_opdata2_o,
             bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o} !== '0) begin n_err++;
            $display("FAIL midop_reset: got start=%0b sgn=%0b op1=%h op2=%h whilo=%0b hi=%h lo=%h stall=%0b want all 0",
                     bus.div_start_o, bus.div_signed_o, bus.div_opdata1_o, bus.div_opdata2_o,
                     bus.whilo_o, bus.hi_o, bus.lo_o, bus.stallreq_o); end
        @(posedge clk); #1;
        run_div(1'b0, 32'd8, 32'd2, -1, 60, lat, nst, sc, an, ob);
        n_cmp++; if (lat !== 37) begin n_err++; $display("FAIL post_reset_lat: got %0d want 37", lat); end
        n_cmp++; if (bus.lo_o !== 32'd4 || bus.hi_o !== 32'd0) begin n_err++;
            $display("FAIL post_reset_result: got lo=%0d hi=%0d want 4/0", bus.lo_o, bus.hi_o); end
    endtask

    task automatic test_fastpath();
        int lat, nst, sc, an; bit ob;
        int exp_lat, exp_sc;
`ifdef DIV_FASTPATH_EN
        exp_lat = 1; exp_sc = 0;
`else
        exp_lat = 37; exp_sc = 36;
`endif
        run_div(1'b0, 32'h1234_5678, 32'd1, -1, 60, lat, nst, sc, an, ob);
        n_cmp++; if (lat !== exp_lat) begin n_err++; $display("FAIL div1_lat: got %0d want %0d", lat, exp_lat); end
        n_cmp++; if (sc !== exp_sc) begin n_err++; $display("FAIL div1_start: got %0d want %0d", sc, exp_sc); end
        n_cmp++; if (nst !== exp_lat) begin n_err++; $display("FAIL div1_stall_end: got %0d want %0d", nst, exp_lat); end
        n_cmp++; if (bus.lo_o !== 32'h1234_5678 || bus.hi_o !== 32'd0) begin n_err++;
            $display("FAIL div1_result: got lo=%h hi=%h want 12345678/0", bus.lo_o, bus.hi_o); end
    endtask

    initial begin
        rst = 1'b0;
        bus.div_req_i = 1'b0; bus.signed_i = 1'b0; bus.flush_i = 1'b0;
        bus.opdata1_i = '0; bus.opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_divu_basic();
        test_div_signed();
        test_div_by_zero();
        test_flush_run();
        test_flush_idle();
        test_flush_collisions();
        test_reset_midop();
        test_fastpath();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
